// File: rtl/sr_shift_sequencer_if.sv
// FIFO and detector shift-register signals of the WRITE-phase sequencer.
// The master side is the sequencer; the slave side is the FIFOs plus the chip.
interface sr_shift_sequencer_if;
  logic [7:0] fifo1_dout;
  logic       fifo1_empty;
  logic       fifo1_valid;
  logic       fifo1_rd_en;
  logic [7:0] fifo2_din;
  logic       fifo2_wr_en;
  logic       fifo2_full;
  logic       sr_clk;
  logic       sr_din;
  logic       sr_dout;
  logic       sr_load;

  modport master (
    input  fifo1_dout, fifo1_empty, fifo1_valid, fifo2_full, sr_dout,
    output fifo1_rd_en, fifo2_din, fifo2_wr_en, sr_clk, sr_din, sr_load
  );

  modport slave (
    output fifo1_dout, fifo1_empty, fifo1_valid, fifo2_full, sr_dout,
    input  fifo1_rd_en, fifo2_din, fifo2_wr_en, sr_clk, sr_din, sr_load
  );
endinterface

// File: rtl/sr_shift_sequencer.sv
// WRITE-phase sequencer: pops config bytes from fifo1, shifts them MSB-first into
// the detector chip on a divided clock, repacks the returned bits into fifo2.
module sr_shift_sequencer #(
  parameter int CLK_DIV  = 50,
  parameter int DIV_W    = 8,
  parameter int LOAD_CYC = 4
) (
  input  logic                  clk_100,
  input  logic                  Reset,
  input  logic                  start,
  input  logic                  abort,
  sr_shift_sequencer_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [15:0]           byte_cnt
);

  localparam int LD_W = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(LOAD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_ACK = 3'd2,
    SHIFT_LO = 3'd3,
    SHIFT_HI = 3'd4,
    STORE    = 3'd5,
    LOAD     = 3'd6,
    DONE     = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [LD_W-1:0]  ld_q, ld_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       f2din_q, f2din_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic             sclk_q, sclk_d;
  logic             sdin_q, sdin_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    ld_d    = ld_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    f2din_d = f2din_q;
    wr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = 16'd0;
          ovf_d   = 1'b0;
          state_d = bus.fifo1_empty ? DONE : FETCH;
        end
      end
      FETCH: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (bus.fifo1_valid) begin
          tx_d    = bus.fifo1_dout;
          bit_d   = 3'd7;
          div_d   = '0;
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          rx_d    = {rx_q[6:0], bus.sr_dout};
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SHIFT_HI: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          tx_d  = {tx_q[6:0], 1'b0};
          if (bit_q == 3'd0) begin
            // The fifo2 write is decided on entry so the strobe lines up with STORE.
            state_d = STORE;
            cnt_d   = sat_inc(cnt_q);
            if (bus.fifo2_full) begin
              ovf_d = 1'b1;
            end else begin
              wr_d    = 1'b1;
              f2din_d = rx_q;
            end
          end else begin
            bit_d   = bit_q - 3'd1;
            state_d = SHIFT_LO;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      STORE: begin
        if (bus.fifo1_empty) begin
          ld_d    = '0;
          state_d = LOAD;
        end else begin
          state_d = FETCH;
        end
      end
      LOAD: begin
        if (ld_q == LD_LAST) state_d = DONE;
        else                 ld_d    = ld_q + LD_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      wr_d    = 1'b0;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      f2din_d = f2din_q;
    end
  end

  // Registered outputs decoded from the state being entered
  always_comb begin
    rd_d   = (state_d == FETCH);
    sclk_d = (state_d == SHIFT_HI);
    load_d = (state_d == LOAD);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    sdin_d = 1'b0;
    if ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) sdin_d = tx_d[7];
  end

  always_ff @(posedge clk_100) begin
    if (Reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      ld_q    <= '0;
      bit_q   <= 3'd0;
      cnt_q   <= 16'd0;
      ovf_q   <= 1'b0;
      f2din_q <= 8'd0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      sclk_q  <= 1'b0;
      sdin_q  <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      ld_q    <= ld_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      f2din_q <= f2din_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      sclk_q  <= sclk_d;
      sdin_q  <= sdin_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Shift registers carry only data and are always overwritten before use
  always_ff @(posedge clk_100) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

  assign bus.fifo1_rd_en = rd_q;
  assign bus.fifo2_din   = f2din_q;
  assign bus.fifo2_wr_en = wr_q;
  assign bus.sr_clk      = sclk_q;
  assign bus.sr_din      = sdin_q;
  assign bus.sr_load     = load_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign overflow        = ovf_q;
  assign byte_cnt        = cnt_q;

endmodule

// File: tb/tb_sr_shift_sequencer.sv
// Bench for sr_shift_sequencer: fifo1/chip models plus a byte-level reference
// of what the chip and fifo2 must see for each sequence.
module tb_sr_shift_sequencer;
  localparam int CLK_DIV  = 2;
  localparam int LOAD_CYC = 3;

  logic        clk_100 = 1'b0;
  logic        Reset, start, abort;
  logic        busy, done, overflow;
  logic [15:0] byte_cnt;

  sr_shift_sequencer_if bus();

  sr_shift_sequencer #(.CLK_DIV(CLK_DIV), .DIV_W(8), .LOAD_CYC(LOAD_CYC)) dut (
    .clk_100(clk_100), .Reset(Reset), .start(start), .abort(abort),
    .bus(bus.master), .busy(busy), .done(done), .overflow(overflow), .byte_cnt(byte_cnt)
  );

  initial forever #5 clk_100 = ~clk_100;

  int errors = 0, checks = 0;
  int mode = 0;        // 0: sr_dout looped to sr_din, 1: tied high, 2: 8-bit chip register
  int ack_delay = 0;
  logic [7:0] chip;
  logic [7:0] src_mem [256];
  int src_wr = 0, src_rd = 0;
  logic [7:0] sent[$];

  int cyc = 0, rises = 0, rd_cnt = 0, load_cnt = 0, done_cnt = 0;
  logic din_bits[$];
  int rise_cyc[$];
  logic [7:0] got2[$];

  assign bus.sr_dout = (mode == 0) ? bus.sr_din : (mode == 1) ? 1'b1 : chip[7];

  initial forever begin
    @(posedge clk_100);
    cyc = cyc + 1;
  end

  // Detector chip: plain 8-bit shift register clocked by sr_clk
  initial begin
    chip = 8'hC3;
    forever begin
      @(posedge bus.sr_clk);
      chip = {chip[6:0], bus.sr_din};
    end
  end

  // fifo1 with read acknowledge delayed by ack_delay cycles
  initial begin
    logic [7:0] pend_data;
    bit pend;
    int pend_cnt;
    pend = 0; pend_cnt = 0; pend_data = 8'd0;
    bus.fifo1_valid = 1'b0; bus.fifo1_dout = 8'd0; bus.fifo1_empty = 1'b1;
    forever begin
      @(negedge clk_100);
      bus.fifo1_valid = 1'b0;
      bus.fifo1_dout  = 8'($urandom);
      if (Reset === 1'b1) pend = 0;
      else if (pend) begin
        if (pend_cnt == 0) begin
          bus.fifo1_valid = 1'b1;
          bus.fifo1_dout  = pend_data;
          pend = 0;
        end else pend_cnt--;
      end
      if (Reset !== 1'b1 && bus.fifo1_rd_en === 1'b1) begin
        pend_data = src_mem[src_rd % 256];
        src_rd++;
        pend = 1;
        pend_cnt = ack_delay;
      end
      bus.fifo1_empty = (src_rd == src_wr);
    end
  end

  // Observer of outputs, sampled mid-cycle
  initial begin
    logic prev_clk;
    prev_clk = 1'b0;
    forever begin
      @(negedge clk_100);
      if (bus.sr_clk === 1'b1 && prev_clk !== 1'b1) begin
        rises++;
        din_bits.push_back(bus.sr_din);
        rise_cyc.push_back(cyc);
      end
      prev_clk = bus.sr_clk;
      if (bus.fifo1_rd_en === 1'b1) rd_cnt++;
      if (bus.sr_load === 1'b1) load_cnt++;
      if (done === 1'b1) done_cnt++;
      if (bus.fifo2_wr_en === 1'b1) got2.push_back(bus.fifo2_din);
    end
  end

  task automatic tick();
    @(negedge clk_100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_byte(input logic [7:0] b);
    src_mem[src_wr % 256] = b;
    src_wr++;
    sent.push_back(b);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " overflow"}, overflow, 0);
    chk({tag, " byte_cnt"}, byte_cnt, 0);
    chk({tag, " sr_clk"}, bus.sr_clk, 0);
    chk({tag, " sr_din"}, bus.sr_din, 0);
    chk({tag, " sr_load"}, bus.sr_load, 0);
    chk({tag, " rd_en"}, bus.fifo1_rd_en, 0);
    chk({tag, " wr_en"}, bus.fifo2_wr_en, 0);
    chk({tag, " fifo2_din"}, bus.fifo2_din, 0);
  endtask

  // Runs one sequence over the bytes in 'sent' and checks it against the byte-level model
  task automatic run_and_check(input string tag, input bit full, input bit restart);
    int b_rise, b_rd, b_ld, b_dn, b_g2, b_din, n, lat;
    bit seen;
    logic [7:0] r0;
    logic [7:0] exp2[$];
    logic [31:0] obs_w, exp_w;
    b_rise = rises; b_rd = rd_cnt; b_ld = load_cnt; b_dn = done_cnt;
    b_g2 = got2.size(); b_din = din_bits.size();
    n = sent.size(); seen = 0; lat = -1;
    bus.fifo2_full = full;
    tick(); tick();
    r0 = chip;
    pulse_start();
    if (restart) begin
      repeat (3) tick();
      chk({tag, " wait_ack sr_clk"}, bus.sr_clk, 0);
      chk({tag, " wait_ack busy"}, busy, 1);
      pulse_start();
    end
    for (int i = 0; i < 4000 && !seen; i++) begin
      if (done_cnt != b_dn) begin seen = 1; lat = i; end
      else tick();
    end
    chk({tag, " done_seen"}, seen, 1);
    if (n == 0) chk({tag, " done_latency_ok"}, (lat >= 0 && lat <= 2), 1);
    repeat (4) tick();
    chk({tag, " sr_clk_rises"}, rises - b_rise, 8 * n);
    chk({tag, " rd_pulses"}, rd_cnt - b_rd, n);
    chk({tag, " load_cycles"}, load_cnt - b_ld, (n > 0) ? LOAD_CYC : 0);
    chk({tag, " done_pulses"}, done_cnt - b_dn, 1);
    chk({tag, " byte_cnt"}, byte_cnt, n);
    chk({tag, " overflow"}, overflow, (full && n > 0) ? 1 : 0);
    chk({tag, " busy_after"}, busy, 0);
    obs_w = '0; exp_w = '0;
    for (int i = 0; i < 8 * n; i++) begin
      obs_w = {obs_w[30:0], (b_din + i < din_bits.size()) ? din_bits[b_din + i] : 1'bx};
      exp_w = {exp_w[30:0], sent[i / 8][7 - (i % 8)]};
    end
    chk({tag, " sr_din_bits"}, obs_w, exp_w);
    if (!full) begin
      for (int i = 0; i < n; i++) begin
        if (mode == 0)      exp2.push_back(sent[i]);
        else if (mode == 1) exp2.push_back(8'hFF);
        else                exp2.push_back((i == 0) ? r0 : sent[i - 1]);
      end
    end
    chk({tag, " fifo2_writes"}, got2.size() - b_g2, exp2.size());
    for (int i = 0; i < exp2.size(); i++)
      chk({tag, $sformatf(" fifo2_byte%0d", i)},
          (b_g2 + i < got2.size()) ? got2[b_g2 + i] : 8'hxx, exp2[i]);
    sent.delete();
  endtask

  initial begin
    int b_rc, b_rise, b_g2, b_ld, b_dn, n;
    bit gap_ok, reached;
    Reset = 1'b1; start = 1'b0; abort = 1'b0; bus.fifo2_full = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    Reset = 1'b0;
    tick();

    // Single byte, loopback, bit period check
    mode = 0; ack_delay = 0;
    load_byte(8'hA5);
    b_rc = rise_cyc.size();
    run_and_check("a5_loop", 1'b0, 1'b0);
    gap_ok = (rise_cyc.size() >= b_rc + 8);
    for (int i = 1; i < 8 && gap_ok; i++)
      if (rise_cyc[b_rc + i] - rise_cyc[b_rc + i - 1] != 2 * CLK_DIV) gap_ok = 0;
    chk("a5_loop bit_period", gap_ok, 1);

    // Three bytes with sr_dout tied high
    mode = 1;
    load_byte(8'h3C); load_byte(8'hFF); load_byte(8'h00);
    run_and_check("three_tied1", 1'b0, 1'b0);

    // Empty fifo1
    mode = 0;
    run_and_check("empty", 1'b0, 1'b0);

    // fifo2 full throughout, then a fresh start clears overflow
    load_byte(8'h12); load_byte(8'h34);
    run_and_check("fifo2_full", 1'b1, 1'b0);
    run_and_check("ovf_clear", 1'b0, 1'b0);

    // Abort in the middle of bit 3
    load_byte(8'h96);
    b_rise = rises; b_g2 = got2.size(); b_ld = load_cnt; b_dn = done_cnt;
    tick(); tick();
    pulse_start();
    reached = 0;
    for (int i = 0; i < 500 && !reached; i++) begin
      if (rises - b_rise >= 3) reached = 1;
      else tick();
    end
    chk("abort reached_bit3", reached, 1);
    repeat (CLK_DIV + 1) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort sr_clk", bus.sr_clk, 0);
    chk("abort sr_load", bus.sr_load, 0);
    repeat (20) tick();
    chk("abort fifo2_writes", got2.size() - b_g2, 0);
    chk("abort load_cycles", load_cnt - b_ld, 0);
    chk("abort done_pulses", done_cnt - b_dn, 0);
    chk("abort byte_cnt_hold", byte_cnt, 0);
    sent.delete();
    load_byte(8'h5E);
    run_and_check("after_abort", 1'b0, 1'b0);

    // Delayed read acknowledge and a start while busy
    mode = 2; ack_delay = 5;
    load_byte(8'hC7); load_byte(8'h29);
    run_and_check("slow_ack", 1'b0, 1'b1);

    // Reset mid-sequence after the first byte has been stored
    mode = 0; ack_delay = 0;
    load_byte(8'h81); load_byte(8'h7E);
    bus.fifo2_full = 1'b1;
    tick(); tick();
    pulse_start();
    repeat (45) tick();
    Reset = 1'b1;
    tick();
    check_zero("mid_reset");
    Reset = 1'b0;
    src_wr = src_rd;
    sent.delete();
    tick();
    load_byte(8'h3A);
    run_and_check("after_reset", 1'b0, 1'b0);

    // Randomized sequences
    for (int k = 0; k < 4; k++) begin
      mode = $urandom_range(0, 2);
      ack_delay = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) load_byte(8'($urandom));
      run_and_check($sformatf("rand%0d", k), ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
